// File: rtl/noc_inst_mem_loader.sv
// Boot loader: takes a program-image packet off the NoC ejection port, writes it
// into instruction memory, verifies the checksum and gates the CPU reset.
module noc_inst_mem_loader #(
  parameter int         ADDR_W   = 12,
  parameter logic [6:0] OPC_LOAD = 7'h01
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  output logic              cpu_reset_req,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, DRAIN, RESP} state_t;

  localparam int LEN_MAX = 1 << ADDR_W;

  function automatic logic [31:0] csum_add(input logic [31:0] acc, input logic [31:0] word);
    return acc + word;
  endfunction

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  state_t            state;
  logic [ADDR_W-1:0] addr_p0;
  logic [ADDR_W:0]   len_p0;
  logic [31:0]       sum_p0;

  logic              xfer;
  logic [6:0]        hdr_opc;
  logic [12:0]       hdr_len;
  logic [ADDR_W-1:0] hdr_addr;
  logic              hdr_bad;
  logic [ADDR_W:0]   ww_next;

  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;

  assign xfer     = in_valid & in_ready;
  assign hdr_opc  = in_data[31:25];
  assign hdr_len  = in_data[24:12];
  assign hdr_addr = in_data[ADDR_W-1:0];
  assign hdr_bad  = (hdr_opc != OPC_LOAD) || (hdr_len == 13'd0) ||
                    ({1'b0, hdr_len} > 14'(LEN_MAX));
  assign ww_next  = words_written + (ADDR_W+1)'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      in_ready       <= 1'b0;
      cpu_reset_req  <= 1'b1;
      load_done      <= 1'b0;
      load_error     <= 1'b0;
      words_written  <= '0;
      mem_address    <= '0;
      mem_writedata  <= '0;
      mem_write      <= 1'b0;
      mem_chipselect <= 1'b0;
      addr_p0        <= '0;
      len_p0         <= '0;
      sum_p0         <= '0;
    end else begin
      mem_write      <= 1'b0;
      mem_chipselect <= 1'b0;
      load_done      <= 1'b0;
      in_ready       <= 1'b1;
      case (state)
        IDLE: if (xfer) begin
          if (in_last) begin
            load_error <= 1'b1;
          end else if (hdr_bad) begin
            load_error <= 1'b1;
            state      <= DRAIN;
          end else begin
            addr_p0       <= hdr_addr;
            len_p0        <= hdr_len[ADDR_W:0];
            sum_p0        <= '0;
            words_written <= '0;
            load_error    <= 1'b0;
            cpu_reset_req <= 1'b1;
            state         <= LOAD;
          end
        end
        // Write stage: the accepted flit becomes a memory write on the next cycle
        LOAD: if (xfer) begin
          mem_write      <= 1'b1;
          mem_chipselect <= 1'b1;
          mem_address    <= addr_p0;
          mem_writedata  <= in_data;
          addr_p0        <= addr_inc(addr_p0);
          sum_p0         <= csum_add(sum_p0, in_data);
          words_written  <= ww_next;
          if (in_last) begin
            load_error <= 1'b1;
            state      <= IDLE;
          end else if (ww_next == len_p0) begin
            state <= CHECK;
          end
        end
        // Result flags are registered on entry so they are visible during RESP
        CHECK: if (xfer) begin
          if (!in_last) begin
            load_error <= 1'b1;
            state      <= DRAIN;
          end else begin
            in_ready <= 1'b0;
            state    <= RESP;
            if (in_data == sum_p0) begin
              load_done     <= 1'b1;
              cpu_reset_req <= 1'b0;
            end else begin
              load_error <= 1'b1;
            end
          end
        end
        DRAIN: if (xfer && in_last) state <= IDLE;
        RESP:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/noc_inst_mem_loader.md
Name: noc_inst_mem_loader

Overview:
- Boot loader between a NoC router's local ejection port and a node's 4096x32 single-port instruction memory (Avalon slave: address, byteenable, chipselect, write, writedata, clken).
- Receives a program-image packet over the NoC, writes its words into instruction memory, and verifies a checksum.
- Holds the node's NIOS CPU in reset until a good image has loaded.

Parameters:
- ADDR_W, 12, instruction-memory word-address width; legal range 8..12.
- OPC_LOAD, 7'h01, header opcode that identifies a load packet.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  flit valid from the router.
- in_ready  out  1  loader accepts a flit this cycle.
- in_data  in  32  flit payload.
- in_last  in  1  final flit of the packet.
- mem_address  out  ADDR_W  instruction-memory word address.
- mem_byteenable  out  4  byte enables; constant 4'hF.
- mem_chipselect  out  1  memory select; high only while writing.
- mem_write  out  1  write strobe.
- mem_writedata  out  32  word to write.
- mem_clken  out  1  memory clock enable; constant 1.
- cpu_reset_req  out  1  holds the CPU in reset.
- load_done  out  1  one-cycle pulse when a load passes its checksum.
- load_error  out  1  sticky error flag; cleared by the next accepted header.
- words_written  out  ADDR_W+1  data words written by the current or last load.

Behaviour:
- Transfer: a flit transfers when in_valid & in_ready are both high.
- Packet format, in order:
  - Header: opcode = bits[31:25], start address = bits[ADDR_W-1:0], len = bits[24:12]. Header bits [11:ADDR_W] are ignored.
  - len data flits.
  - One checksum flit, which must carry in_last.
- Checksum: modulo-2^32 sum of the data words only.
- Reset values: cpu_reset_req=1, in_ready=0 during reset; every other output 0 except mem_byteenable=4'hF and mem_clken=1. State = IDLE.
- FSM states: IDLE, LOAD, CHECK, DRAIN, RESP.
  - IDLE (in_ready=1), header accepted:
    - Header also carries in_last: error -> IDLE.
    - opcode != OPC_LOAD, or len==0, or len > 2^ADDR_W: error -> DRAIN.
    - Otherwise latch address and len; clear sum, words_written and load_error; set cpu_reset_req=1 -> LOAD.
  - LOAD (in_ready=1), per data flit:
    - Register a write: mem_chipselect=mem_write=1 for exactly one cycle, the cycle after acceptance.
    - mem_address = current address; mem_writedata = flit.
    - Then address += 1, wrapping modulo 2^ADDR_W (4095 -> 0 when ADDR_W=12).
    - sum += flit; words_written += 1.
    - in_last on a data flit: write it, then error -> IDLE.
    - After the len-th data flit -> CHECK.
  - CHECK (in_ready=1), on the checksum flit:
    - in_last=0: error -> DRAIN.
    - Mismatch: error -> RESP.
    - Match -> RESP with success.
  - DRAIN (in_ready=1): discard flits without writing; leave on the flit carrying in_last -> IDLE.
  - RESP (in_ready=0, one cycle):
    - Success: load_done=1 for this cycle; cpu_reset_req drops to 0 the same cycle.
    - Error: load_error=1; cpu_reset_req stays 1.
    - Then -> IDLE.
- Error handling:
  - Every error sets load_error.
  - Writes already issued are not rolled back.
  - cpu_reset_req stays 1 until a later successful load.
- Back-to-back data flits produce back-to-back writes; the memory never stalls.
- Gaps: in_valid=0 gaps inside a packet are legal in any state; the FSM holds state.
- Asynchronous reset mid-packet: return to reset values immediately. Any remaining flits of that packet are then parsed as new headers; the sender must resend after reset.

Test Plan:
- Good load: header {OPC_LOAD, len=4, addr=0x010}; data 1,2,3,4; checksum 0xA with last.
  - Writes land at 0x010..0x013 with data 1..4, each one cycle after acceptance.
  - load_done pulses; cpu_reset_req 1->0; words_written=4.
- Wrap-around: addr=0xFFE, len=3, data A,B,C with correct checksum -> writes at 0xFFE, 0xFFF, 0x000; success.
- Bad checksum: same as the good load but checksum 0xB.
  - All 4 writes occur; load_error=1; no load_done; cpu_reset_req stays 1.
  - A following good load clears load_error and releases the CPU.
- Bad header: opcode 7'h02, len=2, then 3 flits with last on the third.
  - No writes; load_error=1; FSM in IDLE after the last flit.
- Early last: len=4, last on the 2nd data flit -> 2 writes, load_error=1, FSM in IDLE. Same test with len=0 in the header -> DRAIN, no writes.
- Mid-load reset: assert reset after 2 of 8 data writes.
  - Outputs go to reset values at once (cpu_reset_req=1, no writes).
  - A full resent packet then succeeds.
- Flow gaps: in_valid toggles 1,0,0,1 within the data phase -> writes stay correct and in order, no spurious mem_write.
